fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register. Consumes PC, issues word fetches to instruction memory, pairs each returned instruction with its PC, and buffers the pair for decode.
- Drives pc_x_4 back into the PC register, which loads every cycle. pc_x_4 therefore encodes advance, hold or redirect.

---
 rtl/fetch_unit_pkg.sv | 8 +
 rtl/fetch_unit_sync_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch slice.
// Imported by the fetch top level.
package fetch_unit_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Synchronous flush clears all entries in one cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wr <= nxt(r_wr);
      if (pop)  r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && empty));
      assert (!(push && full && !pop));
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_cnt;
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-limited imem requests, PC pairing,
// instruction buffer and next-PC mux with redirect drop tracking.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int IBUF_DEPTH      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   PC,
  output logic [XLEN-1:0]   pc_x_4,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]   if_pc
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = $clog2(IBUF_DEPTH) + 1;

  logic [OW-1:0] r_out;
  logic [OW-1:0] r_drop;

  logic [XLEN-1:0]         w_rsp_pc;
  logic [OW-1:0]           w_pc_cnt;
  logic                    w_pc_full;
  logic                    w_pc_empty;
  logic [XLEN+INSTR_W-1:0] w_ib_dout;
  logic [BW-1:0]           w_ib_cnt;
  logic                    w_ib_full;
  logic                    w_ib_empty;
  logic [BW:0]             w_inflight;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_ib_push;
  logic                    w_ib_pop;
  logic                    w_unused;

  // Outstanding + buffered never exceeds the buffer, so responses always fit.
  assign w_inflight = (BW+1)'(r_out) + (BW+1)'(w_ib_cnt);
  assign imem_req_valid = !reset && !redirect_valid &&
                          (r_out < OW'(MAX_OUTSTANDING)) &&
                          (w_inflight < (BW+1)'(IBUF_DEPTH));
  assign w_accept      = imem_req_valid && imem_req_ready;
  assign imem_req_addr = {PC[XLEN-1:2], 2'b00};

  always_comb begin
    pc_x_4 = PC;
    if (!reset) begin
      unique case (1'b1)
        redirect_valid: pc_x_4 = redirect_pc;
        w_accept:       pc_x_4 = PC + PC_STEP;
        default:        pc_x_4 = PC;
      endcase
    end
  end

  assign w_drop    = imem_rsp_valid && ((r_drop != '0) || redirect_valid);
  assign w_ib_push = imem_rsp_valid && !w_drop;
  assign if_valid  = !reset && !w_ib_empty && !redirect_valid;
  assign w_ib_pop  = if_valid && if_ready;
  assign if_pc     = w_ib_dout[XLEN+INSTR_W-1:INSTR_W];
  assign if_instr  = w_ib_dout[INSTR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= r_out + OW'(w_accept) - OW'(imem_rsp_valid);
      if (redirect_valid)
        r_drop <= r_out - OW'(imem_rsp_valid);
      else if (imem_rsp_valid && (r_drop != '0))
        r_drop <= r_drop - 1'b1;
    end
  end

  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .push  (w_accept),
    .pop   (imem_rsp_valid),
    .din   (PC),
    .dout  (w_rsp_pc),
    .count (w_pc_cnt),
    .full  (w_pc_full),
    .empty (w_pc_empty)
  );

  sync_fifo #(.WIDTH(XLEN+INSTR_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (w_ib_push),
    .pop   (w_ib_pop),
    .din   ({w_rsp_pc, imem_rsp_data}),
    .dout  (w_ib_dout),
    .count (w_ib_cnt),
    .full  (w_ib_full),
    .empty (w_ib_empty)
  );

  assign w_unused = &{1'b0, w_pc_cnt, w_pc_full, w_pc_empty, w_ib_full, PC[1:0]};
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a
// behavioural memory, PC register and fetch-stream model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PC;
  logic [31:0] pc_x_4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(.MAX_OUTSTANDING(2), .IBUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .PC(PC), .pc_x_4(pc_x_4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  // PC register of the surrounding pipeline: loads every cycle.
  always @(posedge clk or posedge reset)
    if (reset) PC <= '0;
    else PC <= pc_x_4;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] expq[$];
  int          vec = 0;
  int          errs = 0;
  int          cyc = 0;
  int          model_buf = 0;
  logic [31:0] model_pc = '0;
  bit          prev_redir = 0;
  int          pr_ready, pr_ifrdy, pr_redir, lat_min, lat_max;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit exp_rv, acc, cons, rsp;
    logic [31:0] exp_nx;
    mreq_t h;
    @(negedge clk);
    cyc++;
    imem_req_ready = ($urandom_range(99) < pr_ready);
    if_ready       = ($urandom_range(99) < pr_ifrdy);
    redirect_valid = !prev_redir && ($urandom_range(99) < pr_redir);
    redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8
                                              : ($urandom() & 32'hFFFF_FFFC);
    rsp = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(memq[0].addr) : $urandom();
    #1;
    exp_rv = !redirect_valid && (memq.size() < 2) &&
             (memq.size() + model_buf < 2);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("if_valid", 32'(if_valid), 32'(model_buf > 0 && !redirect_valid));
    acc  = exp_rv && imem_req_ready;
    cons = (model_buf > 0) && !redirect_valid && if_ready;
    exp_nx = redirect_valid ? redirect_pc : (acc ? PC + 32'd4 : PC);
    chk("pc_x_4", pc_x_4, exp_nx);
    if (acc) begin
      chk("req_addr", imem_req_addr, model_pc);
      memq.push_back('{model_pc, cyc + $urandom_range(lat_max, lat_min), 1'b0});
      expq.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 32'd4;
    end
    if (cons) model_buf--;
    if (rsp) begin
      h = memq.pop_front();
      if (!h.stale && !redirect_valid) model_buf++;
    end
    if (redirect_valid) begin
      model_buf = 0;
      foreach (memq[i]) memq[i].stale = 1'b1;
      expq.delete();
      model_pc = redirect_pc;
    end
    prev_redir = redirect_valid;
  endtask

  task automatic phase(input int n, input int rdy, input int ifr,
                       input int rd, input int lmin, input int lmax);
    pr_ready = rdy; pr_ifrdy = ifr; pr_redir = rd;
    lat_min = lmin; lat_max = lmax;
    repeat (n) step();
  endtask

  // Monitor: compares every decode handshake with the scoreboard head.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && if_valid && if_ready) begin
        if (expq.size() == 0) begin
          vec++; errs++;
          $display("FAIL unexpected_instr cyc=%0d got pc=%h want none",
                   cyc, if_pc);
        end else begin
          e = expq.pop_front();
          chk("if_pc", if_pc, e[63:32]);
          chk("if_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_pc_x_4", pc_x_4, PC);
    end
    @(negedge clk);
    reset = 1'b0;
    phase(20, 100, 100, 0, 1, 1);
    phase(4, 0, 100, 0, 1, 1);
    phase(10, 100, 0, 0, 1, 1);
    phase(10, 100, 100, 0, 1, 1);
    phase(200, 60, 60, 0, 1, 3);
    phase(300, 100, 100, 10, 3, 3);
    phase(400, 70, 70, 12, 1, 4);
    phase(300, 100, 100, 20, 1, 1);
    pr_ready = 100; pr_ifrdy = 100; pr_redir = 0;
    lat_min = 1; lat_max = 1;
    guard = 0;
    while ((memq.size() > 0 || model_buf > 0) && guard < 50) begin
      step();
      guard++;
    end
    repeat (2) @(negedge clk);
    chk("drain_bound", 32'(guard < 50), 32'd1);
    chk("drain_empty", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
